// File: rtl/ramfill_pkg.sv
// Shared types and helpers for the triggered multi-channel ADC capture buffer.
package ramfill_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StArmed,
        StPost,
        StDone
    } state_e;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    function automatic int unsigned depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/ramfill_trig_if.sv
// VGA-side read port of the capture buffer: pixel index and channel in, sample out.
interface ramfill_trig_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CH_W   = 1
);

    logic [ADDR_W-1:0] CounterX;
    logic [CH_W-1:0]   rd_ch;
    logic [DATA_W-1:0] vga_data;

    modport master (
        output CounterX,
        output rd_ch,
        input  vga_data
    );

    modport slave (
        input  CounterX,
        input  rd_ch,
        output vga_data
    );

endinterface

// File: rtl/ramfill_trig_detect.sv
// Level/slope trigger detector: tracks the previous stored sample and flags a crossing.
module ramfill_trig_detect
    import ramfill_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_adc,
    input  logic              reset,
    input  logic              clear,
    input  logic              strobe,
    input  logic              eval,
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] level,
    input  logic              slope,
    input  logic              free_run,
    output logic              hit
);

    logic [DATA_W-1:0] prev;
    logic              prev_valid;
    logic              cross_rise;
    logic              cross_fall;
    logic              crossed;

    always_ff @(posedge clk_adc or negedge reset) begin
        if (!reset) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (clear) begin
            prev_valid <= 1'b0;
        end else if (strobe) begin
            prev       <= cur;
            prev_valid <= 1'b1;
        end
    end

    always_comb begin
        cross_rise = (prev < level) && (cur >= level);
        cross_fall = (prev > level) && (cur <= level);
        crossed    = (slope == SLOPE_FALL) ? cross_fall : cross_rise;
        // Free-run fires on the first evaluated strobe regardless of history.
        hit        = strobe && eval && (free_run || (prev_valid && crossed));
    end

endmodule

// File: rtl/ramfill_trig.sv
// Multi-channel circular capture around a level/slope trigger, with a
// trigger-aligned registered read port for the VGA renderer.
module ramfill_trig
    import ramfill_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEC_W    = 8
) (
    input  logic                                               clk_adc,
    input  logic                                               reset,
    input  logic                                               enable,
    input  logic [CHANNELS*DATA_W-1:0]                         adc_data,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] trig_ch,
    input  logic [DATA_W-1:0]                                  trig_level,
    input  logic                                               trig_slope,
    input  logic                                               free_run,
    input  logic [ADDR_W-1:0]                                  pre_count,
    input  logic [DEC_W-1:0]                                   decim,
    ramfill_trig_if.slave                                      vga,
    output logic                                               finished,
    output logic                                               armed,
    output logic                                               triggered
);

    localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned DEPTH = depth(ADDR_W);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            st;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] pre_q;
    logic [DEC_W-1:0]  decim_q;
    logic [DEC_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  post_tgt;
    logic [CH_W-1:0]   trig_ch_q;
    logic [DATA_W-1:0] level_q;
    logic              slope_q;
    logic              free_run_q;

    logic              capturing;
    logic              strobe;
    logic              wr_en;
    logic              hit;
    logic [DATA_W-1:0] trig_cur;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word [CHANNELS];
    logic [DATA_W-1:0] rd_sel;
    logic [DATA_W-1:0] vga_data_q;

    always_comb begin
        capturing = (st == StPre) || (st == StArmed) || (st == StPost);
        strobe    = capturing && (div_cnt == decim_q);
        // Abort beats a coincident strobe: nothing is written once enable drops.
        wr_en     = strobe && enable;
        post_tgt  = CNT_W'(DEPTH) - CNT_W'(pre_q);
        rd_addr   = trig_addr - pre_q + vga.CounterX;
    end

    always_comb begin
        trig_cur = '0;
        rd_sel   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (trig_ch_q == CH_W'(k)) trig_cur = adc_data[k*DATA_W +: DATA_W];
            if (vga.rd_ch == CH_W'(k)) rd_sel = rd_word[k];
        end
    end

    ramfill_trig_detect #(
        .DATA_W (DATA_W)
    ) u_detect (
        .clk_adc  (clk_adc),
        .reset    (reset),
        .clear    (st == StIdle),
        .strobe   (wr_en),
        .eval     (st == StArmed),
        .cur      (trig_cur),
        .level    (level_q),
        .slope    (slope_q),
        .free_run (free_run_q),
        .hit      (hit)
    );

    always_ff @(posedge clk_adc or negedge reset) begin
        if (!reset) begin
            st         <= StIdle;
            wr_ptr     <= '0;
            trig_addr  <= '0;
            pre_q      <= '0;
            decim_q    <= '0;
            div_cnt    <= '0;
            cnt        <= '0;
            trig_ch_q  <= '0;
            level_q    <= '0;
            slope_q    <= 1'b0;
            free_run_q <= 1'b0;
            finished   <= 1'b0;
            armed      <= 1'b0;
            triggered  <= 1'b0;
        end else begin
            triggered <= 1'b0;
            case (st)
                StIdle: begin
                    div_cnt <= '0;
                    if (enable) begin
                        pre_q      <= pre_count;
                        decim_q    <= decim;
                        trig_ch_q  <= trig_ch;
                        level_q    <= trig_level;
                        slope_q    <= trig_slope;
                        free_run_q <= free_run;
                        wr_ptr     <= '0;
                        cnt        <= '0;
                        if (pre_count == '0) begin
                            st    <= StArmed;
                            armed <= 1'b1;
                        end else begin
                            st <= StPre;
                        end
                    end
                end
                StPre, StArmed, StPost: begin
                    if (!enable) begin
                        st    <= StIdle;
                        armed <= 1'b0;
                    end else begin
                        if (strobe) begin
                            div_cnt <= '0;
                            wr_ptr  <= wr_ptr + 1'b1;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                        if (st == StPre && strobe) begin
                            if (cnt + CNT_ONE == CNT_W'(pre_q)) begin
                                cnt   <= '0;
                                st    <= StArmed;
                                armed <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                        if (hit) begin
                            trig_addr <= wr_ptr;
                            triggered <= 1'b1;
                            armed     <= 1'b0;
                            // The trigger sample is itself the first post sample.
                            if (post_tgt == CNT_ONE) begin
                                st       <= StDone;
                                finished <= 1'b1;
                            end else begin
                                cnt <= CNT_ONE;
                                st  <= StPost;
                            end
                        end
                        if (st == StPost && strobe) begin
                            if (cnt + CNT_ONE == post_tgt) begin
                                st       <= StDone;
                                finished <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                    end
                end
                StDone: begin
                    if (!enable) begin
                        st       <= StIdle;
                        finished <= 1'b0;
                    end
                end
                default: st <= StIdle;
            endcase
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];

        always_ff @(posedge clk_adc) begin
            if (wr_en) mem[wr_ptr] <= adc_data[k*DATA_W +: DATA_W];
        end

        assign rd_word[k] = mem[rd_addr];
    end

    always_ff @(posedge clk_adc or negedge reset) begin
        if (!reset) vga_data_q <= '0;
        else        vga_data_q <= rd_sel;
    end

    assign vga.vga_data = vga_data_q;

endmodule

// File: tb/tb_ramfill_trig.sv
// Bench for ramfill_trig: randomized captures checked against a sample-stream model.
module tb_ramfill_trig;

    localparam int DEPTH = 256;
    localparam int MAXC  = 4096;

    logic        clk_adc = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] adc_data = '0;
    logic        trig_ch = 1'b0;
    logic [7:0]  trig_level = '0;
    logic        trig_slope = 1'b0;
    logic        free_run = 1'b0;
    logic [7:0]  pre_count = '0;
    logic [7:0]  decim = '0;
    logic        finished;
    logic        armed;
    logic        triggered;

    ramfill_trig_if #(.DATA_W(8), .ADDR_W(8), .CH_W(1)) vga ();

    ramfill_trig #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .CHANNELS (2),
        .DEC_W    (8)
    ) u_dut (
        .clk_adc    (clk_adc),
        .reset      (reset),
        .enable     (enable),
        .adc_data   (adc_data),
        .trig_ch    (trig_ch),
        .trig_level (trig_level),
        .trig_slope (trig_slope),
        .free_run   (free_run),
        .pre_count  (pre_count),
        .decim      (decim),
        .vga        (vga),
        .finished   (finished),
        .armed      (armed),
        .triggered  (triggered)
    );

    always #5 clk_adc = ~clk_adc;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [7:0]  dat [2][MAXC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Clock index (counted from the cycle after the start edge) of stored sample n.
    function automatic int scyc(input int n, input int d);
        return n * (d + 1) + d;
    endfunction

    function automatic int find_trig(input int pre, input int d, input int ch, input int lvl,
                                     input bit slope, input bit fr);
        for (int n = pre; scyc(n + DEPTH, d) + 20 < MAXC; n++) begin
            int cur = dat[ch][scyc(n, d)];
            int prv = (n >= 1) ? int'(dat[ch][scyc(n - 1, d)]) : 0;
            if (fr) return n;
            if (n >= 1 && !slope && prv < lvl && cur >= lvl) return n;
            if (n >= 1 && slope && prv > lvl && cur <= lvl) return n;
        end
        return -1;
    endfunction

    task automatic gen_data(input int mode);
        for (int j = 0; j < MAXC; j++) begin
            case (mode)
                0: begin
                    dat[0][j] = 8'(j);
                    dat[1][j] = 8'($urandom);
                end
                1: begin
                    dat[0][j] = 8'($urandom);
                    dat[1][j] = 8'(255 - (j % 256));
                end
                default: begin
                    dat[0][j] = 8'($urandom);
                    dat[1][j] = 8'($urandom);
                end
            endcase
        end
    endtask

    // Called at a negedge; result is visible one clock later.
    task automatic do_read(input int x, input int c, input int exp, input string tag);
        vga.CounterX = 8'(x);
        vga.rd_ch    = 1'(c);
        adc_data     = 16'($urandom);
        @(negedge clk_adc);
        check(tag, vga.vga_data, exp);
    endtask

    task automatic release_cap();
        @(negedge clk_adc);
        check("rel_fin_hi", finished, 1);
        enable = 1'b0;
        @(negedge clk_adc);
        check("rel_fin_lo", finished, 0);
        check("rel_armed", armed, 0);
    endtask

    // abort_off: abort this many cycles after ARMED begins; reset_off: reset this
    // many cycles after the trigger pulse. Negative disables either.
    task automatic capture(input int pre, input int d, input int ch, input int lvl,
                           input bit slope, input bit fr_in, input int mode,
                           input int abort_off, input int reset_off);
        int nt, it, idone, arm0, stop;
        int trig_cyc, fin_cyc, arm_first, arm_cnt, ntrig, x, c;
        bit fr;
        fr = fr_in;
        gen_data(mode);
        nt = find_trig(pre, d, ch, lvl, slope, fr);
        if (nt < 0) begin
            fr = 1'b1;
            nt = find_trig(pre, d, ch, lvl, slope, fr);
        end
        it    = scyc(nt, d);
        idone = scyc(nt + DEPTH - pre - 1, d);
        arm0  = (pre == 0) ? 0 : scyc(pre - 1, d) + 1;
        stop  = idone + 21;
        if (abort_off >= 0) stop = arm0 + abort_off;
        if (reset_off >= 0) stop = it + 1 + reset_off;

        @(posedge clk_adc); #1;
        pre_count  = 8'(pre);
        decim      = 8'(d);
        trig_ch    = 1'(ch);
        trig_level = 8'(lvl);
        trig_slope = slope;
        free_run   = fr;
        enable     = 1'b1;
        @(posedge clk_adc); #1;
        // Config is latched now; later changes must be ignored.
        pre_count  = 8'($urandom);
        decim      = 8'($urandom);
        trig_ch    = 1'($urandom);
        trig_level = 8'($urandom);
        trig_slope = 1'($urandom);
        free_run   = 1'($urandom);

        trig_cyc = -1; fin_cyc = -1; arm_first = -1; arm_cnt = 0; ntrig = 0;
        for (int j = 0; j < stop; j++) begin
            adc_data = {dat[1][j], dat[0][j]};
            @(negedge clk_adc);
            if (triggered) begin
                ntrig++;
                if (trig_cyc < 0) trig_cyc = j;
            end
            if (armed) begin
                arm_cnt++;
                if (arm_first < 0) arm_first = j;
            end
            if (finished && fin_cyc < 0) fin_cyc = j;
            if (finished) break;
            @(posedge clk_adc); #1;
        end

        if (abort_off >= 0) begin
            adc_data = {dat[1][stop], dat[0][stop]};
            enable   = 1'b0;
            @(negedge clk_adc);
            check("abort_armed_hold", armed, 1);
            @(negedge clk_adc);
            check("abort_armed_low", armed, 0);
            check("abort_fin", finished, 0);
            repeat (3) @(negedge clk_adc);
            check("abort_fin_stays", finished, 0);
            return;
        end

        if (reset_off >= 0) begin
            reset = 1'b0;
            #1;
            check("rst_fin", finished, 0);
            check("rst_armed", armed, 0);
            check("rst_trig", triggered, 0);
            check("rst_vga", vga.vga_data, 0);
            @(negedge clk_adc);
            @(negedge clk_adc);
            enable = 1'b0;
            reset  = 1'b1;
            @(negedge clk_adc);
            check("rst_idle_armed", armed, 0);
            check("rst_idle_fin", finished, 0);
            return;
        end

        check("trig_cycle", trig_cyc, it + 1);
        check("trig_pulses", ntrig, 1);
        check("armed_first", arm_first, arm0);
        check("armed_cycles", arm_cnt, it + 1 - arm0);
        check("fin_cycle", fin_cyc, idone + 1);

        for (int r = 0; r < 9; r++) begin
            case (r)
                0: x = 0;
                1: x = pre;
                2: x = 255;
                default: x = $urandom_range(0, 255);
            endcase
            c = (r < 3) ? ch : int'($urandom_range(0, 1));
            do_read(x, c, dat[c][scyc(nt - pre + x, d)], "read");
        end
    endtask

    initial begin
        vga.CounterX = '0;
        vga.rd_ch    = '0;
        repeat (3) @(posedge clk_adc);
        #1;
        check("reset_fin", finished, 0);
        check("reset_armed", armed, 0);
        check("reset_trig", triggered, 0);
        check("reset_vga", vga.vga_data, 0);
        @(negedge clk_adc);
        reset = 1'b1;

        // Rising ramp on ch0, level 128, 64 pre samples.
        capture(64, 0, 0, 128, 1'b0, 1'b0, 0, -1, -1);
        do_read(64, 0, 128, "t1_x64");
        do_read(0, 0, 64, "t1_x0");
        release_cap();

        // Falling ramp on ch1, no pre-trigger window.
        capture(0, 0, 1, 100, 1'b1, 1'b0, 1, -1, -1);
        do_read(0, 1, 100, "t2_x0");
        release_cap();

        // Decimated free-run.
        capture(10, 3, 0, int'($urandom_range(0, 255)), 1'b0, 1'b1, 2, -1, -1);
        release_cap();

        // Read-address wrap: trigger lands at address 30 with 200 pre samples.
        capture(200, 0, 0, 30, 1'b0, 1'b0, 0, -1, -1);
        do_read(0, 0, 86, "t4_x0");
        do_read(255, 0, 85, "t4_x255");
        release_cap();

        // Abort while armed, then a fresh capture.
        capture(20, 0, 0, 255, 1'b0, 1'b0, 0, 5, -1);
        capture(20, 0, 0, 200, 1'b0, 1'b0, 0, -1, -1);
        release_cap();

        // Reset during post-trigger fill, then a fresh capture.
        capture(32, 1, 0, int'($urandom_range(40, 200)), 1'b0, 1'b0, 2, -1, 20);
        capture(32, 1, 0, int'($urandom_range(40, 200)), 1'b0, 1'b0, 2, -1, -1);
        release_cap();

        for (int t = 0; t < 5; t++) begin
            capture(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 1)), int'($urandom_range(20, 235)),
                    1'($urandom), ($urandom_range(0, 3) == 0), 2, -1, -1);
            release_cap();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
